// File: rtl/tenbaset_pkg.sv
// ============================================================================
//  Module      : tenbaset_pkg
//  Description : Shared types and constants for the 10BASE-T receive and
//                transmit paths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tenbaset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    localparam int MIN_FRAME_DEFAULT = 64;
    localparam int MAX_FRAME_DEFAULT = 1518;

    // One byte of CRC-32, data bits consumed LSB first as they arrive on the wire.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ data[i]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tenbaset_manchester_dec.sv
// ============================================================================
//  Module      : tenbaset_manchester_dec
//  Description : Manchester bit recovery: input synchroniser, mid-bit edge
//                blanking and carrier-loss timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tenbaset_manchester_dec #(
    parameter int SAMPLES_PER_BIT = 8
) (
    input  logic clk80,
    input  logic rst_n,
    input  logic rd_in,
    output logic bit_data,
    output logic bit_stb,
    output logic carrier
);

    localparam int BLANK   = (SAMPLES_PER_BIT * 3) / 4;
    localparam int TIMEOUT = (SAMPLES_PER_BIT * 3) / 2;
    localparam int CW      = $clog2(TIMEOUT + 1);

    logic          sync_1;
    logic          sync_2;
    logic          line_q;
    logic [CW-1:0] blank_cnt;
    logic [CW-1:0] idle_cnt;
    logic          edge_seen;
    logic          accept;

    assign edge_seen = sync_2 ^ line_q;
    // Bit-boundary edges fall inside the blanking window and are discarded.
    assign accept    = edge_seen && (blank_cnt == '0);

    always_ff @(posedge clk80 or negedge rst_n) begin
        if (!rst_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            line_q    <= 1'b0;
            blank_cnt <= '0;
            idle_cnt  <= '0;
            bit_data  <= 1'b0;
            bit_stb   <= 1'b0;
            carrier   <= 1'b0;
        end else begin
            sync_1  <= rd_in;
            sync_2  <= sync_1;
            line_q  <= sync_2;
            bit_stb <= accept;
            if (accept) begin
                bit_data  <= sync_2;
                blank_cnt <= CW'(BLANK);
                idle_cnt  <= '0;
                carrier   <= 1'b1;
            end else begin
                if (blank_cnt != '0) begin
                    blank_cnt <= blank_cnt - 1'b1;
                end
                if (carrier) begin
                    if (idle_cnt == CW'(TIMEOUT - 1)) begin
                        carrier <= 1'b0;
                    end
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tenbaset_rxd.sv
// ============================================================================
//  Module      : tenbaset_rxd
//  Description : 10BASE-T receiver: preamble/SFD hunt, byte assembly, length
//                and CRC-32 status. CRC checking is built only when the macro
//                TENBASET_RXD_CRC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tenbaset_rxd
    import tenbaset_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 8,
    parameter int MIN_FRAME       = MIN_FRAME_DEFAULT,
    parameter int MAX_FRAME       = MAX_FRAME_DEFAULT
) (
    input  logic       clk80,
    input  logic       rst_n,
    input  logic       Ethernet_RD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_crc_ok,
    output logic       rx_err
);

    localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_CNT = 11'(MAX_FRAME);
    localparam logic [10:0] SAT_CNT = 11'h7FF;

    logic        bit_data;
    logic        bit_stb;
    logic        carrier;

    rx_state_t   state;
    logic [14:0] pre_sh;
    logic [4:0]  pre_cnt;
    logic [2:0]  bit_cnt;
    logic [6:0]  byte_sh;
    logic [10:0] byte_cnt;
    logic [15:0] pre_next;
    logic [7:0]  byte_next;
`ifdef TENBASET_RXD_CRC_EN
    logic [31:0] crc;
`endif

    tenbaset_manchester_dec #(
        .SAMPLES_PER_BIT (SAMPLES_PER_BIT)
    ) u_dec (
        .clk80    (clk80),
        .rst_n    (rst_n),
        .rd_in    (Ethernet_RD),
        .bit_data (bit_data),
        .bit_stb  (bit_stb),
        .carrier  (carrier)
    );

    assign pre_next  = {bit_data, pre_sh};
    assign byte_next = {bit_data, byte_sh};

    always_ff @(posedge clk80 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pre_sh    <= '0;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            byte_sh   <= '0;
            byte_cnt  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_crc_ok <= 1'b0;
            rx_err    <= 1'b0;
`ifdef TENBASET_RXD_CRC_EN
            crc       <= CRC_INIT;
`endif
        end else begin
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_crc_ok <= 1'b0;
            rx_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bit_stb) begin
                        state   <= ST_PREAMBLE;
                        pre_sh  <= {bit_data, 14'b0};
                        pre_cnt <= 5'd1;
                    end
                end
                ST_PREAMBLE: begin
                    if (!carrier) begin
                        state <= ST_IDLE;
                    end else if (bit_stb) begin
                        pre_sh <= pre_next[15:1];
                        if (pre_cnt != 5'd16) begin
                            pre_cnt <= pre_cnt + 5'd1;
                        end
                        // Demanding a preamble octet ahead of the SFD keeps a
                        // receiver joining mid-frame from locking onto payload.
                        if (pre_next == {SFD, PREAMBLE_BYTE} && pre_cnt >= 5'd15) begin
                            state    <= ST_DATA;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
`ifdef TENBASET_RXD_CRC_EN
                            crc      <= CRC_INIT;
`endif
                        end
                    end
                end
                ST_DATA, ST_DROP: begin
                    if (!carrier) begin
                        state  <= ST_IDLE;
                        rx_eof <= 1'b1;
                        rx_err <= (byte_cnt < MIN_CNT) || (byte_cnt > MAX_CNT);
`ifdef TENBASET_RXD_CRC_EN
                        rx_crc_ok <= (crc == CRC_RESIDUE);
`else
                        rx_crc_ok <= 1'b1;
`endif
                    end else if (bit_stb) begin
                        byte_sh <= byte_next[7:1];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt != SAT_CNT) begin
                                byte_cnt <= byte_cnt + 11'd1;
                            end
`ifdef TENBASET_RXD_CRC_EN
                            crc <= crc32_byte(crc, byte_next);
`endif
                            if (state == ST_DATA) begin
                                if (byte_cnt >= MAX_CNT) begin
                                    state <= ST_DROP;
                                end else begin
                                    rx_valid <= 1'b1;
                                    rx_data  <= byte_next;
                                    rx_sof   <= (byte_cnt == 11'd0);
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tenbaset_rxd.sv
// ============================================================================
//  Module      : tb_tenbaset_rxd
//  Description : Self-checking bench for tenbaset_rxd using Manchester
//                waveforms built from random frames and a CRC/length model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tenbaset_rxd;

    localparam int SPB   = 8;
    localparam int MIN_F = 64;
    localparam int MAX_F = 100;
`ifdef TENBASET_RXD_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int RST_BIT = (8 + 20) * 8 + 4;

    logic       clk80 = 1'b0;
    logic       rst_n = 1'b0;
    logic       Ethernet_RD = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sof;
    logic       rx_eof;
    logic       rx_crc_ok;
    logic       rx_err;

    tenbaset_rxd #(
        .SAMPLES_PER_BIT (SPB),
        .MIN_FRAME       (MIN_F),
        .MAX_FRAME       (MAX_F)
    ) dut (
        .clk80       (clk80),
        .rst_n       (rst_n),
        .Ethernet_RD (Ethernet_RD),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_crc_ok   (rx_crc_ok),
        .rx_err      (rx_err)
    );

    always #5 clk80 = ~clk80;

    int         total  = 0;
    int         passed = 0;
    logic [7:0] got_q[$];
    int         sof_cnt, sof_pos, eof_cnt;
    logic       eof_crc, eof_err;
    logic [7:0] fr[$];
    logic [7:0] fr_b[$];
    logic       txbits[$];

    always @(negedge clk80) begin
        if (rx_valid) begin
            if (rx_sof) begin
                sof_cnt++;
                sof_pos = got_q.size();
            end
            got_q.push_back(rx_data);
        end
        if (rx_eof) begin
            eof_cnt++;
            eof_crc = rx_crc_ok;
            eof_err = rx_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        got_q.delete();
        sof_cnt = 0;
        sof_pos = -1;
        eof_cnt = 0;
        eof_crc = 1'b0;
        eof_err = 1'b0;
    endtask

    // Reflected CRC-32 as used by Ethernet software stacks.
    function automatic logic [31:0] ref_fcs(input logic [7:0] b[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic logic model_crc_ok(input logic [7:0] b[$]);
        int n;
        n = b.size();
        return CRC_EN ? (ref_fcs(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]}) : 1'b1;
    endfunction

    task automatic make_frame(input int n);
        logic [31:0] c;
        fr.delete();
        for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
        c = ref_fcs(fr, n - 4);
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    endtask

    task automatic build_bits(input logic [7:0] b[$], input int dribble);
        logic [7:0] v;
        txbits.delete();
        for (int i = 0; i < 8 + b.size(); i++) begin
            v = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : b[i-8];
            for (int k = 0; k < 8; k++) txbits.push_back(v[k]);
        end
        for (int i = 0; i < dribble; i++) txbits.push_back(1'($urandom));
    endtask

    function automatic bit has_sfd_window(input int start);
        logic [15:0] pat;
        bit          m;
        pat = 16'hD555;
        for (int s = start; s + 16 <= txbits.size(); s++) begin
            m = 1'b1;
            for (int k = 0; k < 16; k++) if (txbits[s+k] != pat[k]) m = 1'b0;
            if (m) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int jit(input bit en);
        return en ? int'($urandom_range(0, 2)) - 1 : 0;
    endfunction

    // Bit i: first half carries ~b, second half b; boundary and mid edges
    // may each move by one cycle, keeping mid-to-mid spacing >= 7 cycles.
    task automatic send(input bit jitter, input int rst_cycle);
        int   n, jm, prev_jm, len;
        int   bt[$];
        int   mt[$];
        logic lvl[];
        n = txbits.size();
        prev_jm = 0;
        for (int i = 0; i < n; i++) begin
            jm = jit(jitter);
            if (jm < prev_jm - 1) jm = prev_jm - 1;
            prev_jm = jm;
            bt.push_back(8*i + ((i == 0) ? 0 : jit(jitter)));
            mt.push_back(8*i + 4 + jm);
        end
        bt.push_back(8*n + jit(jitter));
        len = 8*n + 48;
        lvl = new[len];
        for (int t = 0; t < len; t++) lvl[t] = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int t = bt[i]; t < mt[i]; t++) lvl[t] = ~txbits[i];
            for (int t = mt[i]; t < bt[i+1]; t++) lvl[t] = txbits[i];
        end
        for (int t = 0; t < len; t++) begin
            @(posedge clk80);
            #1;
            Ethernet_RD = lvl[t];
            if (t == rst_cycle) rst_n = 1'b0;
            if (t == rst_cycle + 1) begin
                check("midrst_valid", {31'h0, rx_valid}, 32'h0);
                check("midrst_data", {24'h0, rx_data}, 32'h0);
                check("midrst_eof", {31'h0, rx_eof}, 32'h0);
            end
            if (t == rst_cycle + 3) rst_n = 1'b1;
        end
    endtask

    // Expected results derive from what was transmitted: bytes beyond MAX_F
    // are suppressed, length outside [MIN_F, MAX_F] flags an error.
    task automatic check_frame(input string tag, input logic [7:0] b[$], input int exp_n,
                               input int exp_eof, input bit chk_crc);
        int bad;
        int nb;
        bad = 0;
        nb  = b.size();
        check({tag, "_count"}, got_q.size(), exp_n);
        for (int i = 0; i < got_q.size() && i < exp_n; i++) if (got_q[i] !== b[i]) bad++;
        check({tag, "_bytes"}, bad, 0);
        check({tag, "_sofcnt"}, sof_cnt, (exp_n > 0) ? 1 : 0);
        if (exp_n > 0) check({tag, "_sofpos"}, sof_pos, 0);
        check({tag, "_eofcnt"}, eof_cnt, exp_eof);
        if (exp_eof > 0) begin
            check({tag, "_err"}, {31'h0, eof_err}, {31'h0, (nb < MIN_F) || (nb > MAX_F)});
            if (chk_crc) check({tag, "_crc"}, {31'h0, eof_crc}, {31'h0, model_crc_ok(b)});
        end
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge clk80);
        #1;
        check("rst_data", {24'h0, rx_data}, 32'h0);
        check("rst_valid", {31'h0, rx_valid}, 32'h0);
        check("rst_sof", {31'h0, rx_sof}, 32'h0);
        check("rst_eof", {31'h0, rx_eof}, 32'h0);
        check("rst_crc", {31'h0, rx_crc_ok}, 32'h0);
        check("rst_err", {31'h0, rx_err}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk80);

        // Minimum-length good frame
        clear_mon();
        make_frame(64);
        build_bits(fr, 0);
        send(1'b0, -100);
        check_frame("t1", fr, 64, 1, 1'b1);

        // Same frame with one payload bit flipped
        clear_mon();
        fr_b = fr;
        fr_b[$urandom_range(0, 59)] ^= 8'h01 << $urandom_range(0, 7);
        build_bits(fr_b, 0);
        send(1'b0, -100);
        check_frame("t2", fr_b, 64, 1, 1'b1);

        // Runt, exact maximum, and oversize frames
        clear_mon();
        make_frame(60);
        build_bits(fr, 0);
        send(1'b0, -100);
        check_frame("t3_runt", fr, 60, 1, 1'b1);

        clear_mon();
        make_frame(MAX_F);
        build_bits(fr, 0);
        send(1'b0, -100);
        check_frame("t3_max", fr, MAX_F, 1, 1'b1);

        clear_mon();
        make_frame(MAX_F + 30);
        build_bits(fr, 0);
        send(1'b0, -100);
        check_frame("t3_long", fr, MAX_F, 1, 1'b0);

        // Link pulses and a truncated preamble
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk80); #1; Ethernet_RD = 1'b1;
            repeat (SPB) @(posedge clk80);
            #1; Ethernet_RD = 1'b0;
            repeat (200) @(posedge clk80);
        end
        txbits.delete();
        for (int i = 0; i < 10; i++) txbits.push_back(1'(~i[0]));
        send(1'b0, -100);
        check("t4_valid", got_q.size(), 0);
        check("t4_eof", eof_cnt, 0);

        // Reset in the middle of byte 20, then a clean frame
        clear_mon();
        for (int a = 0; a < 50; a++) begin
            make_frame(64);
            build_bits(fr, 0);
            if (!has_sfd_window(RST_BIT)) break;
        end
        send(1'b0, RST_BIT * SPB);
        check_frame("t5_abort", fr, 20, 0, 1'b0);

        clear_mon();
        make_frame(64);
        build_bits(fr, 0);
        send(1'b0, -100);
        check_frame("t5_clean", fr, 64, 1, 1'b1);

        // Edge jitter plus dribble bits
        clear_mon();
        make_frame(64);
        build_bits(fr, 3);
        send(1'b1, -100);
        check_frame("t6", fr, 64, 1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
